// File: rtl/clock_time_ctrl_if.sv
// Button/tick inputs and BCD time/mode outputs of clock_time_ctrl.
// With CLOCK_ALARM_EN defined, mode widens to 3 bits and alarm_on/alarm are added.
interface clock_time_ctrl_if;
`ifdef CLOCK_ALARM_EN
   localparam int MODE_W = 3;
`else
   localparam int MODE_W = 2;
`endif

   logic              tick_1hz;
   logic              btn_mode;
   logic              btn_inc;
   logic [7:0]        hour;
   logic [7:0]        minute;
   logic [7:0]        second;
   logic [MODE_W-1:0] mode;
   logic              blink;
   logic              day_carry;
`ifdef CLOCK_ALARM_EN
   logic              alarm_on;
   logic              alarm;
`endif

   modport master (
      output tick_1hz, btn_mode, btn_inc,
`ifdef CLOCK_ALARM_EN
      output alarm_on,
      input  alarm,
`endif
      input  hour, minute, second, mode, blink, day_carry
   );

   modport slave (
      input  tick_1hz, btn_mode, btn_inc,
`ifdef CLOCK_ALARM_EN
      input  alarm_on,
      output alarm,
`endif
      output hour, minute, second, mode, blink, day_carry
   );
endinterface

// File: rtl/clock_time_ctrl.sv
// Digital-clock sequencer: BCD hour/minute/second registers plus the run/set mode FSM.
// Optional alarm (CLOCK_ALARM_EN) adds alarm registers and two extra set states.
//
// state     | meaning
// RUN       | time advances on tick_1hz, btn_inc ignored
// SET_HOUR  | btn_inc steps hour, tick toggles blink
// SET_MIN   | btn_inc steps minute, tick toggles blink; leaving clears second
// SET_ALM_H | (alarm build) btn_inc steps alm_hour
// SET_ALM_M | (alarm build) btn_inc steps alm_min
module clock_time_ctrl #(
   parameter logic [7:0] HOUR_MAX = 8'h23,
   parameter logic [7:0] MIN_MAX  = 8'h59
) (
   input logic               clk,
   input logic               reset,
   clock_time_ctrl_if.slave  bus
);
`ifdef CLOCK_ALARM_EN
   localparam logic [2:0] RUN       = 3'd0;
   localparam logic [2:0] SET_HOUR  = 3'd1;
   localparam logic [2:0] SET_MIN   = 3'd2;
   localparam logic [2:0] SET_ALM_H = 3'd3;
   localparam logic [2:0] SET_ALM_M = 3'd4;
   localparam int         MODE_W    = 3;
`else
   localparam logic [1:0] RUN       = 2'd0;
   localparam logic [1:0] SET_HOUR  = 2'd1;
   localparam logic [1:0] SET_MIN   = 2'd2;
   localparam int         MODE_W    = 2;
`endif

   logic [7:0]        hour_q, minute_q, second_q;
   logic [7:0]        hour_n, minute_n, second_n;
   logic [MODE_W-1:0] mode_q, mode_n;
   logic              blink_q, blink_n;
   logic              carry_q, carry_n;
`ifdef CLOCK_ALARM_EN
   logic [7:0]        alm_hour_q, alm_min_q, alm_hour_n, alm_min_n;
   logic              alarm_q, alarm_n;
`endif

   // Wrap at max_v, otherwise carry units 9 into tens so digits stay 0-9.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
      if (v == max_v)
         return 8'h00;
      else if (v[3:0] == 4'h9)
         return {v[7:4] + 4'h1, 4'h0};
      else
         return {v[7:4], v[3:0] + 4'h1};
   endfunction

   always_comb begin
      hour_n   = hour_q;
      minute_n = minute_q;
      second_n = second_q;
      mode_n   = mode_q;
      blink_n  = blink_q;
      carry_n  = 1'b0;
`ifdef CLOCK_ALARM_EN
      alm_hour_n = alm_hour_q;
      alm_min_n  = alm_min_q;
`endif
      case (mode_q)
         RUN: begin
            blink_n = 1'b0;
            if (bus.tick_1hz) begin
               second_n = bcd_inc(second_q, MIN_MAX);
               if (second_q == MIN_MAX) begin
                  minute_n = bcd_inc(minute_q, MIN_MAX);
                  if (minute_q == MIN_MAX) begin
                     hour_n  = bcd_inc(hour_q, HOUR_MAX);
                     carry_n = (hour_q == HOUR_MAX);
                  end
               end
            end
            if (bus.btn_mode)
               mode_n = SET_HOUR;
         end
         SET_HOUR: begin
            if (bus.btn_mode) begin
               mode_n  = SET_MIN;
               blink_n = 1'b0;
            end else begin
               if (bus.tick_1hz) blink_n = ~blink_q;
               if (bus.btn_inc)  hour_n  = bcd_inc(hour_q, HOUR_MAX);
            end
         end
         SET_MIN: begin
            if (bus.btn_mode) begin
`ifdef CLOCK_ALARM_EN
               mode_n   = SET_ALM_H;
`else
               mode_n   = RUN;
`endif
               second_n = 8'h00;
               blink_n  = 1'b0;
            end else begin
               if (bus.tick_1hz) blink_n  = ~blink_q;
               if (bus.btn_inc)  minute_n = bcd_inc(minute_q, MIN_MAX);
            end
         end
`ifdef CLOCK_ALARM_EN
         SET_ALM_H: begin
            if (bus.btn_mode) begin
               mode_n  = SET_ALM_M;
               blink_n = 1'b0;
            end else begin
               if (bus.tick_1hz) blink_n    = ~blink_q;
               if (bus.btn_inc)  alm_hour_n = bcd_inc(alm_hour_q, HOUR_MAX);
            end
         end
         SET_ALM_M: begin
            if (bus.btn_mode) begin
               mode_n  = RUN;
               blink_n = 1'b0;
            end else begin
               if (bus.tick_1hz) blink_n   = ~blink_q;
               if (bus.btn_inc)  alm_min_n = bcd_inc(alm_min_q, MIN_MAX);
            end
         end
`endif
         default: begin
            mode_n  = RUN;
            blink_n = 1'b0;
         end
      endcase
   end

`ifdef CLOCK_ALARM_EN
   // The matching tick itself changes the minute, so the match outranks the minute-change clear.
   always_comb begin
      alarm_n = alarm_q;
      if (!bus.alarm_on)
         alarm_n = 1'b0;
      else if (mode_q == RUN && bus.btn_inc)
         alarm_n = 1'b0;
      else if (mode_q == RUN && bus.tick_1hz && hour_n == alm_hour_q &&
               minute_n == alm_min_q && second_n == 8'h00)
         alarm_n = 1'b1;
      else if (minute_n != minute_q)
         alarm_n = 1'b0;
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         hour_q   <= 8'h00;
         minute_q <= 8'h00;
         second_q <= 8'h00;
         mode_q   <= RUN;
         blink_q  <= 1'b0;
         carry_q  <= 1'b0;
`ifdef CLOCK_ALARM_EN
         alm_hour_q <= 8'h00;
         alm_min_q  <= 8'h00;
         alarm_q    <= 1'b0;
`endif
      end else begin
         hour_q   <= hour_n;
         minute_q <= minute_n;
         second_q <= second_n;
         mode_q   <= mode_n;
         blink_q  <= blink_n;
         carry_q  <= carry_n;
`ifdef CLOCK_ALARM_EN
         alm_hour_q <= alm_hour_n;
         alm_min_q  <= alm_min_n;
         alarm_q    <= alarm_n;
`endif
      end
   end

   assign bus.hour      = hour_q;
   assign bus.minute    = minute_q;
   assign bus.second    = second_q;
   assign bus.mode      = mode_q;
   assign bus.blink     = blink_q;
   assign bus.day_carry = carry_q;
`ifdef CLOCK_ALARM_EN
   assign bus.alarm     = alarm_q;
`endif
endmodule
